// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right/left, parallel load,
// with frame tracking that pulses o_done after WIDTH shifts following a load.
module universal_shift_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_sdi_r,
  input  logic             i_sdi_l,
  input  logic [WIDTH-1:0] i_pdata,
  output logic [WIDTH-1:0] o_pdata,
  output logic             o_sdo_r,
  output logic             o_sdo_l,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data;
  logic             done;
  logic             is_shift;
  logic             is_load;

  assign is_shift = i_mode[0] ^ i_mode[1];
  assign is_load  = i_mode[0] & i_mode[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data  <= RST_VAL;
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (!i_en) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (i_mode)
        2'b00: data <= data;
        2'b01: data <= {i_sdi_r, data[WIDTH-1:1]};
        2'b10: data <= {data[WIDTH-2:0], i_sdi_l};
        2'b11: data <= i_pdata;
      endcase
      // A load always (re)starts a frame, abandoning any frame in flight.
      if (is_load) begin
        state <= SHIFT;
        cnt   <= '0;
      end else if (is_shift && state == SHIFT) begin
        if (cnt == LAST) begin
          state <= IDLE;
          cnt   <= '0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign o_pdata = data;
  assign o_sdo_r = data[0];
  assign o_sdo_l = data[WIDTH-1];
  assign o_busy  = (state == SHIFT);
  assign o_done  = done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised bench for universal_shift_register (WIDTH=8)
// against a frame-level behavioural model.
module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       sdi_r;
  logic       sdi_l;
  logic [7:0] pdi;
  logic [7:0] pdo;
  logic       sdo_r;
  logic       sdo_l;
  logic       busy;
  logic       done;

  int checks;
  int fails;

  logic [7:0] m_reg;
  bit         m_frame;
  int         m_cnt;
  bit         m_done;

  universal_shift_register #(
    .WIDTH  (8),
    .RST_VAL(8'h00)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_mode (mode),
    .i_sdi_r(sdi_r),
    .i_sdi_l(sdi_l),
    .i_pdata(pdi),
    .o_pdata(pdo),
    .o_sdo_r(sdo_r),
    .o_sdo_l(sdo_l),
    .o_busy (busy),
    .o_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_reg   = 8'h00;
    m_frame = 1'b0;
    m_cnt   = 0;
    m_done  = 1'b0;
  endtask

  // Drive one clock edge; the model follows the frame rules directly.
  task automatic step(input bit e, input bit [1:0] md,
                      input bit sr, input bit sl,
                      input bit [7:0] pd);
    en    = e;
    mode  = md;
    sdi_r = sr;
    sdi_l = sl;
    pdi   = pd;
    @(posedge clk);
    m_done = 1'b0;
    if (e) begin
      if (md == 2'd1) m_reg = (m_reg >> 1) | (8'(sr) << 7);
      if (md == 2'd2) m_reg = (m_reg << 1) | 8'(sl);
      if (md == 2'd3) begin
        m_reg   = pd;
        m_frame = 1'b1;
        m_cnt   = 0;
      end else if (md != 2'd0 && m_frame) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_done  = 1'b1;
          m_frame = 1'b0;
          m_cnt   = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      en    = 1'($urandom);
      mode  = 2'($urandom);
      sdi_r = 1'($urandom);
      sdi_l = 1'($urandom);
      pdi   = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (pdo !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold pdata=%h busy=%b done=%b want 00/0/0",
                 pdo, busy, done);
      end
    end
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (pdo !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release pdata=%h busy=%b want 00/0", pdo, busy);
    end
    step(1'b0, 2'd3, 1'b1, 1'b1, 8'h5A);
    checks++;
    if (pdo !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_en0 pdata=%h busy=%b done=%b want 00/0/0",
               pdo, busy, done);
    end
  endtask

  task automatic test_right_frame();
    logic [7:0] pat;
    pat = 8'hA5;
    step(1'b1, 2'd3, 1'b0, 1'b0, pat);
    checks++;
    if (pdo !== pat || busy !== 1'b1) begin
      fails++;
      $display("FAIL right_load pdata=%h busy=%b want a5/1", pdo, busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sdo_r !== pat[i] || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL right_sdo[%0d] sdo=%b busy=%b done=%b want %b/1/0",
                 i, sdo_r, busy, done, pat[i]);
      end
      step(1'b1, 2'd1, 1'b0, 1'($urandom), 8'($urandom));
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pdo !== 8'h00) begin
      fails++;
      $display("FAIL right_done done=%b busy=%b pdata=%h want 1/0/00",
               done, busy, pdo);
    end
    step(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL right_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_left_frame();
    logic [7:0] pat;
    int         n_done;
    pat    = 8'h3C;
    n_done = 0;
    step(1'b1, 2'd3, 1'b0, 1'b0, pat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sdo_l !== pat[7-i]) begin
        fails++;
        $display("FAIL left_sdo[%0d] sdo=%b want %b", i, sdo_l, pat[7-i]);
      end
      step(1'b1, 2'd2, 1'($urandom), 1'b1, 8'($urandom));
      if (done === 1'b1) n_done++;
    end
    step(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    if (done === 1'b1) n_done++;
    checks++;
    if (pdo !== 8'hFF || n_done != 1) begin
      fails++;
      $display("FAIL left_end pdata=%h dones=%0d want ff/1", pdo, n_done);
    end
  endtask

  task automatic test_enable_hold();
    logic [7:0] snap;
    step(1'b1, 2'd3, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd1, 1'($urandom), 1'b0, 8'h00);
    snap = pdo;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        step(1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      else
        step(1'b1, 2'd0, 1'($urandom), 1'($urandom), 8'($urandom));
      checks++;
      if (pdo !== snap || done !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall[%0d] pdata=%h done=%b busy=%b want %h/0/1",
                 i, pdo, done, busy, snap);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd1, 1'($urandom), 1'b0, 8'h00);
      checks++;
      if (done !== (i == 4) || pdo !== m_reg) begin
        fails++;
        $display("FAIL hold_shift[%0d] done=%b pdata=%h want %b/%h",
                 i, done, pdo, (i == 4), m_reg);
      end
    end
  endtask

  task automatic test_reload();
    int n_done;
    n_done = 0;
    step(1'b1, 2'd3, 1'b0, 1'b0, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      if (done === 1'b1) n_done++;
    end
    step(1'b1, 2'd3, 1'b0, 1'b0, 8'h0F);
    if (done === 1'b1) n_done++;
    checks++;
    if (n_done != 0 || busy !== 1'b1 || pdo !== 8'h0F) begin
      fails++;
      $display("FAIL reload_mid dones=%0d busy=%b pdata=%h want 0/1/0f",
               n_done, busy, pdo);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (done !== (i == 7)) begin
        fails++;
        $display("FAIL reload_done[%0d] done=%b want %b", i, done, (i == 7));
      end
    end
    checks++;
    if (pdo !== 8'h00) begin
      fails++;
      $display("FAIL reload_end pdata=%h want 00", pdo);
    end
  endtask

  task automatic test_async_reset();
    int n_done;
    n_done = 0;
    step(1'b1, 2'd3, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pdo !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_rst pdata=%h busy=%b done=%b want 00/0/0",
               pdo, busy, done);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd1 + 2'($urandom_range(0, 1)), 1'($urandom),
           1'($urandom), 8'h00);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_after dones=%0d busy=%b want 0/0", n_done, busy);
    end
  endtask

  task automatic test_random();
    bit [1:0] md;
    for (int i = 0; i < 400; i++) begin
      md = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 7) != 0), md, 1'($urandom),
           1'($urandom), 8'($urandom));
      checks++;
      if (pdo !== m_reg || sdo_r !== m_reg[0] || sdo_l !== m_reg[7] ||
          busy !== m_frame || done !== m_done) begin
        fails++;
        $display("FAIL rand[%0d] got %h/%b%b/%b/%b want %h/%b%b/%b/%b",
                 i, pdo, sdo_r, sdo_l, busy, done,
                 m_reg, m_reg[0], m_reg[7], m_frame, m_done);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    en     = 1'b0;
    mode   = 2'd0;
    sdi_r  = 1'b0;
    sdi_l  = 1'b0;
    pdi    = 8'h00;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_right_frame();
    test_left_frame();
    test_enable_hold();
    test_reload();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
